inst_mem_loader: RTL

Sequencing controller for the byte-organised instruction memory (32 bytes, 8 instructions, big-endian: byte addr+0 holds bits [31:24]). It accepts 32-bit instruction words over a valid/ready handshake and writes each one into memory as four consecutive byte writes. While a load session is active, it stalls CPU instruction fetch, so the fetch path and the loader never touch the memory in the same cycle. It sits between the program-load source (testbench or boot stream) and `inst_mem`.

---
 rtl/inst_mem_loader_pkg.sv | 28 ++
 rtl/inst_mem_loader_word_byte_ser.sv | 39 +++
 rtl/inst_mem_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, word geometry
// and the big-endian byte selector.
package inst_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD  = 4;
  localparam int DEF_DEPTH_BYTES = 32;
  localparam int DEF_WORDS       = DEF_DEPTH_BYTES / BYTES_PER_WORD;

  // Byte 0 is the most significant byte of the word (big-endian memory layout).
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/inst_mem_loader_word_byte_ser.sv
// Word capture register and byte index; presents the byte that follows the one
// currently on the memory write bus, and flags when the final byte is on the bus.
module inst_mem_loader_word_byte_ser
  import inst_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] word_in,
  output logic [1:0]  nxt_idx,
  output logic [7:0]  nxt_byte,
  output logic        last
);

  logic [31:0] word;
  logic [1:0]  idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (load) begin
      idx <= '0;
    end else if (advance) begin
      idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      word <= word_in;
    end
  end

  assign nxt_idx  = idx + 2'd1;
  assign nxt_byte = get_byte(word, nxt_idx);
  assign last     = (idx == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Program-load sequencer: accepts 32-bit words and writes them into the byte-wide
// instruction memory as four big-endian byte writes, stalling CPU fetch meanwhile.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DEPTH_BYTES = DEF_DEPTH_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              fetch_stall,
  output logic              busy,
  output logic              full,
  output logic [3:0]        word_count
);

  localparam logic [3:0] WORDS_C = 4'(DEPTH_BYTES / BYTES_PER_WORD);

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic              done_pend;
  logic              accept;
  logic [ADDR_W-1:0] base;
  logic [1:0]        ser_nxt_idx;
  logic [7:0]        ser_byte;
  logic              ser_last;

  assign in_ready    = (state == ST_WAIT);
  assign busy        = (state != ST_IDLE);
  assign fetch_stall = busy;
  assign mem_raddr   = fetch_addr;
  assign accept      = in_ready && in_valid;
  // A restart coinciding with an accept writes the word at the cleared pointer.
  assign base        = load_start ? '0 : wptr;

  inst_mem_loader_word_byte_ser u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .advance  (state == ST_WRITE),
    .word_in  (in_data),
    .nxt_idx  (ser_nxt_idx),
    .nxt_byte (ser_byte),
    .last     (ser_last)
  );

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= WORDS_C) ? WORDS_C : c + 4'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      wptr       <= '0;
      word_count <= '0;
      done_pend  <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      full       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state      <= ST_WAIT;
            wptr       <= '0;
            word_count <= '0;
            done_pend  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (in_valid) begin
            // First byte goes out straight from the input so writes start next cycle.
            state     <= ST_WRITE;
            mem_we    <= 1'b1;
            mem_waddr <= base;
            mem_wdata <= get_byte(in_data, 2'd0);
            done_pend <= load_done;
            if (load_start) begin
              wptr       <= '0;
              word_count <= '0;
            end
          end else if (load_start) begin
            wptr       <= '0;
            word_count <= '0;
            done_pend  <= 1'b0;
          end else if (load_done) begin
            state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (ser_last) begin
            mem_we     <= 1'b0;
            wptr       <= wptr + ADDR_W'(BYTES_PER_WORD);
            word_count <= sat_inc(word_count);
            done_pend  <= 1'b0;
            if (sat_inc(word_count) == WORDS_C) begin
              state <= ST_FULL;
              full  <= 1'b1;
            end else if (done_pend || load_done) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            mem_waddr <= {wptr[ADDR_W-1:2], ser_nxt_idx};
            mem_wdata <= ser_byte;
            if (load_done) begin
              done_pend <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (load_start) begin
            state      <= ST_WAIT;
            full       <= 1'b0;
            wptr       <= '0;
            word_count <= '0;
            done_pend  <= 1'b0;
          end else if (load_done) begin
            state <= ST_IDLE;
            full  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
